// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo counter: direction/mode encodings and the
// decoded count-update operation.
package mod_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // What the count register does on the next edge.
  typedef enum logic [2:0] {
    OpHold,
    OpLoad,
    OpInc,
    OpDec,
    OpZero,
    OpMax
  } count_op_e;

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable-gated prescaler: ticks once every (i_presc+1) enabled cycles.
module mod_counter_prescaler #(
  parameter int unsigned PW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [PW-1:0] i_presc,
  output logic          o_tick
);

  logic [PW-1:0] pcnt_q, pcnt_d;

  // A phase beyond a freshly lowered divisor counts as a tick so it cannot run away.
  assign o_tick = (pcnt_q >= i_presc);

  always_comb begin
    pcnt_d = pcnt_q;
    if (i_clr) begin
      pcnt_d = '0;
    end else if (i_en) begin
      pcnt_d = o_tick ? '0 : pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with runtime bound, wrap or saturate mode, synchronous
// load and prescaler. o_tc pulses on terminal steps; o_sat holds while pinned.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned CW = 16,
  parameter int unsigned PW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dir,
  input  logic          i_sat,
  input  logic [CW-1:0] i_max,
  input  logic [PW-1:0] i_presc,
  output logic [CW-1:0] o_count,
  output logic          o_tc,
  output logic          o_sat
);

  logic [CW-1:0] count_q, count_d;
  logic          tc_q, tc_d;
  logic          sat_q, sat_d;
  logic          tick, step, sat_mode;
  count_op_e     op;

  mod_counter_prescaler #(
    .PW(PW)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_clr   (i_load),
    .i_presc (i_presc),
    .o_tick  (tick)
  );

  assign step     = i_en & tick;
  assign sat_mode = (i_sat == MODE_SAT);

  // Decode the step outcome and the terminal flags.
  always_comb begin
    op    = OpHold;
    tc_d  = 1'b0;
    sat_d = sat_q & sat_mode;
    if (i_load) begin
      op    = OpLoad;
      sat_d = 1'b0;
    end else if (step) begin
      sat_d = 1'b0;
      if (i_dir == DIR_UP) begin
        if (count_q < i_max) begin
          op    = OpInc;
          sat_d = sat_mode && (count_q == i_max - CW'(1));
          tc_d  = sat_d;
        end else if (!sat_mode) begin
          op   = OpZero;
          tc_d = 1'b1;
        end else begin
          op    = OpMax;
          tc_d  = ~sat_q;
          sat_d = 1'b1;
        end
      end else begin
        if (count_q > i_max) begin
          op = OpMax;
        end else if (count_q == '0) begin
          if (!sat_mode) begin
            op   = OpMax;
            tc_d = 1'b1;
          end else begin
            op    = OpZero;
            tc_d  = ~sat_q;
            sat_d = 1'b1;
          end
        end else begin
          op    = OpDec;
          sat_d = sat_mode && (count_q == CW'(1));
          tc_d  = sat_d;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case (op)
      OpHold: count_d = count_q;
      OpLoad: count_d = (i_load_val > i_max) ? i_max : i_load_val;
      OpInc:  count_d = count_q + CW'(1);
      OpDec:  count_d = count_q - CW'(1);
      OpZero: count_d = '0;
      OpMax:  count_d = i_max;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      sat_q   <= sat_d;
    end
  end

  assign o_count = count_q;
  assign o_tc    = tc_q;
  assign o_sat   = sat_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed and randomized bench for mod_counter against an arithmetic reference model.
module tb_mod_counter;

  localparam int unsigned CW = 16;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic          dir = 1'b1;
  logic          sat = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic [CW-1:0] max = '0;
  logic [PW-1:0] presc = '0;
  logic [CW-1:0] count;
  logic          tc;
  logic          sat_o;

  int checks = 0;
  int errors = 0;

  // Reference state: expected outputs after the most recent clock edge.
  int unsigned m_cnt = 0;
  int unsigned m_pc  = 0;
  bit          m_tc  = 1'b0;
  bit          m_sat = 1'b0;

  int unsigned e1c[5] = '{1, 2, 3, 0, 1};
  int unsigned e1t[5] = '{0, 0, 0, 1, 0};
  int unsigned e3c[4] = '{4, 5, 5, 5};
  int unsigned e3t[4] = '{0, 1, 0, 0};
  int unsigned e3s[4] = '{0, 1, 1, 1};

  always #5 clk = ~clk;

  mod_counter #(
    .CW(CW),
    .PW(PW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_load     (load),
    .i_load_val (load_val),
    .i_dir      (dir),
    .i_sat      (sat),
    .i_max      (max),
    .i_presc    (presc),
    .o_count    (count),
    .o_tc       (tc),
    .o_sat      (sat_o)
  );

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_next();
    int unsigned mx = max;
    int unsigned c  = m_cnt;
    bit          hit;
    if (rst) begin
      m_cnt = 0; m_pc = 0; m_tc = 0; m_sat = 0;
      return;
    end
    if (load) begin
      m_cnt = (load_val > mx) ? mx : load_val;
      m_pc = 0; m_tc = 0; m_sat = 0;
      return;
    end
    hit = en && (m_pc >= presc);
    if (en) m_pc = hit ? 0 : m_pc + 1;
    m_tc = 0;
    if (!hit) begin
      m_sat = m_sat && sat;
      return;
    end
    if (dir) begin
      if (c + 1 <= mx) begin
        m_cnt = c + 1;
        m_sat = sat && (m_cnt == mx);
        m_tc  = m_sat;
      end else if (!sat) begin
        m_cnt = 0; m_tc = 1; m_sat = 0;
      end else begin
        m_cnt = mx; m_tc = !m_sat; m_sat = 1;
      end
    end else begin
      if (c > mx) begin
        m_cnt = mx; m_sat = 0;
      end else if (c == 0) begin
        if (!sat) begin
          m_cnt = mx; m_tc = 1; m_sat = 0;
        end else begin
          m_cnt = 0; m_tc = !m_sat; m_sat = 1;
        end
      end else begin
        m_cnt = c - 1;
        m_sat = sat && (m_cnt == 0);
        m_tc  = m_sat;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("model_count", count, m_cnt);
    chk("model_tc", tc, m_tc);
    chk("model_sat", sat_o, m_sat);
  endtask

  task automatic cyc();
    model_next();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc();
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_sat", sat_o, 0);

    // Wrap at bound 3
    rst = 1'b0; en = 1'b1; dir = 1'b1; sat = 1'b0; max = 16'd3; presc = '0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t1_count", count, e1c[i]);
      chk("t1_tc", tc, e1t[i]);
    end

    // Prescaler and enable freeze
    rst = 1'b1;
    cyc();
    rst = 1'b0; presc = 8'd2; max = 16'hFFFF; en = 1'b1;
    repeat (9) cyc();
    chk("t2_count9", count, 3);
    en = 1'b0;
    repeat (5) cyc();
    chk("t2_frozen", count, 3);
    en = 1'b1;
    repeat (2) cyc();
    chk("t2_phase", count, 3);
    cyc();
    chk("t2_resume", count, 4);

    // Saturate up, then reverse
    presc = '0; sat = 1'b1; max = 16'd5; load_val = 16'd3; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_count", count, e3c[i]);
      chk("t3_tc", tc, e3t[i]);
      chk("t3_sat", sat_o, e3s[i]);
    end
    dir = 1'b0;
    cyc();
    chk("t3_rev_count", count, 4);
    chk("t3_rev_sat", sat_o, 0);

    // Down wrap and down saturate
    sat = 1'b0; max = 16'd9; load_val = 16'd1; load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    chk("t4_wrap_zero", count, 0);
    cyc();
    chk("t4_wrap_max", count, 9);
    chk("t4_wrap_tc", tc, 1);
    sat = 1'b1; load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    chk("t4_sat_land", count, 0);
    chk("t4_sat_land_tc", tc, 1);
    chk("t4_sat_land_sat", sat_o, 1);
    cyc();
    chk("t4_sat_hold", count, 0);
    chk("t4_sat_hold_tc", tc, 0);
    chk("t4_sat_hold_sat", sat_o, 1);

    // Load clamp and reset over load
    sat = 1'b0; max = 16'd10; load_val = 16'd20; load = 1'b1;
    cyc();
    chk("t5_clamp", count, 10);
    rst = 1'b1;
    cyc();
    chk("t5_rst_over_load", count, 0);
    rst = 1'b0; load = 1'b0;

    // Count above a lowered bound
    max = 16'hFFFF; load_val = 16'd50; load = 1'b1;
    cyc();
    load = 1'b0; max = 16'd10; dir = 1'b1;
    cyc();
    chk("t6_up_count", count, 0);
    chk("t6_up_tc", tc, 1);
    max = 16'hFFFF; load = 1'b1;
    cyc();
    load = 1'b0; max = 16'd10; dir = 1'b0;
    cyc();
    chk("t6_dn_count", count, 10);
    chk("t6_dn_tc", tc, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 3) != 0);
      load_val = CW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 14));
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0) sat = ~sat;
      if ($urandom_range(0, 31) == 0)
        max = CW'($urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 12));
      if ($urandom_range(0, 63) == 0) presc = PW'($urandom_range(0, 3));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
